instruction_fetch_unit: RTL and testbench
=========================================

// Module: instruction_fetch_unit
// PURPOSE
//  Fetch stage directly upstream of the instruction memory: owns the PC, drives the
//  memory word address, and registers the returned 32-bit instruction into an
//  IF/ID buffer with a valid/ready handshake towards decode. It accepts branch
//  redirects from execute and stops fetching on HALT (opcode bits [31:26]).
// PARAMETERS
//  PC_W     7          PC width in bits; memory depth = 2**PC_W = 128 words
//  RESET_PC 0          word address fetched first after start
//  HALT_OP  6'b111000  opcode that stops fetch
// PORTS
//  clk            in   1   rising-edge clock
//  rsta_n         in   1   synchronous active-low reset
//  start          in   1   one-cycle pulse: begin fetching from RESET_PC
//  imem_addr      out  32  word address to memory, {zeros, pc}; memory reads combinationally
//  imem_data      in   32  instruction returned for imem_addr (same cycle)
//  redirect_valid in   1   execute requests PC change (taken br/bz/bmi)
//  redirect_pc    in   32  target word address; only bits [PC_W-1:0] used
//  id_ready       in   1   decode accepts if_instr this cycle
//  if_valid       out  1   if_instr/if_pc hold a valid instruction
//  if_instr       out  32  registered instruction
//  if_pc          out  32  word address of if_instr, zero-extended
//  halted         out  1   HALT has been fetched; no further fetch
//  pc_wrapped     out  1   sticky: PC incremented past 2**PC_W-1
// BEHAVIOUR
//  Reset (rsta_n=0 at posedge): state=IDLE, pc=RESET_PC, if_valid=0, if_instr=0,
//   if_pc=0, halted=0, pc_wrapped=0. Reset overrides every other input.
//  States: IDLE -> FETCH on start; FETCH -> HALTED when a HALT word is loaded;
//   HALTED -> FETCH on redirect_valid (HALT was on a wrong path); else stays.
//  adv = (state==FETCH) && (!if_valid || id_ready)  -- buffer free or draining.
//  Priority per posedge (highest first):
//   1 redirect_valid (any non-IDLE state): pc<=redirect_pc[PC_W-1:0], if_valid<=0,
//     halted<=0, state<=FETCH. The buffered instruction is flushed even if
//     id_ready=1 (decode must ignore it in that cycle).
//   2 adv: if_instr<=imem_data, if_pc<=pc, if_valid<=1; if imem_data[31:26]==HALT_OP
//     then pc holds, halted<=1, state<=HALTED; else pc<=pc+1.
//   3 if_valid && id_ready (not adv, i.e. HALTED/IDLE): if_valid<=0.
//   4 otherwise hold pc and the buffer (stall).
//  Latency: instruction at pc appears on if_instr one cycle after the adv edge;
//   one instruction per cycle sustained while id_ready=1.
//  Wrap: pc=2**PC_W-1 increments to 0 and sets pc_wrapped (sticky until reset).
//  start while not IDLE: ignored. redirect_valid in IDLE: ignored.
//  imem_addr is combinational from pc only; never from redirect_pc in the same cycle.
// STRUCTURE
//  Shared package cpu_pkg: opcode constants (OP_HALT, OP_BR, OP_BZ, OP_BMI, ...),
//   fetch state enum {IDLE, FETCH, HALTED}, INSTR_W=32.
//  Single module; optional sub-module if_buffer (valid/ready register holding
//   instr+pc) is natural but not required.
// TESTING
//  1 Reset, start; memory holds 12-word program, HALT at 11, id_ready=1 ->
//    if_pc 0..11 on consecutive cycles; halted=1 the cycle HALT appears; pc stays 11.
//  2 id_ready=0 for 3 cycles with if_pc=2 -> if_instr/if_pc held, imem_addr stays 3;
//    on release if_pc=3 the next cycle.
//  3 redirect_valid, redirect_pc=2 while if_pc=6 -> next cycle if_valid=0,
//    imem_addr=2; the cycle after that if_pc=2.
//  4 Redirect and id_ready=0 in the same cycle after HALT was fetched ->
//    halted=0, state FETCH, fetch resumes at target.
//  5 PC_W=7, jump to 127 with no HALT -> next if_pc=0, pc_wrapped=1 and sticky.
//  6 rsta_n=0 mid-stream with if_valid=1 -> all outputs at reset values next cycle;
//    start required to resume from 0.

Source files
------------

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared opcode constants, instruction width and fetch state
package cpu_pkg;
  localparam int INSTR_W = 32;
  localparam logic [5:0] OP_HALT = 6'b111000;
  localparam logic [5:0] OP_BR = 6'b000100;
  localparam logic [5:0] OP_BZ = 6'b000101;
  localparam logic [5:0] OP_BMI = 6'b000110;
  typedef enum logic [1:0] {IDLE, FETCH, HALTED} fetch_state_t;
endpackage

// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit: PC owner and IF/ID buffer with redirect and halt handling
import cpu_pkg::*;
module instruction_fetch_unit #(
  parameter int PC_W = 7,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter logic [5:0] HALT_OP = OP_HALT
) (
  input  logic               clk,
  input  logic               rsta_n,
  input  logic               start,
  output logic [31:0]        imem_addr,
  input  logic [INSTR_W-1:0] imem_data,
  input  logic               redirect_valid,
  input  logic [31:0]        redirect_pc,
  input  logic               id_ready,
  output logic               if_valid,
  output logic [INSTR_W-1:0] if_instr,
  output logic [31:0]        if_pc,
  output logic               halted,
  output logic               pc_wrapped
);
  fetch_state_t state;
  logic [PC_W-1:0] pc;
  logic adv, is_halt, unused_redirect_hi;
  assign adv = state == FETCH && (!if_valid || id_ready);
  assign is_halt = imem_data[31:26] == HALT_OP;
  assign imem_addr = {{(32-PC_W){1'b0}}, pc};
  assign unused_redirect_hi = ^redirect_pc[31:PC_W];
  always_ff @(posedge clk) begin
    if (!rsta_n) begin
      state <= IDLE;
      pc <= RESET_PC;
      if_valid <= 1'b0;
      if_instr <= '0;
      if_pc <= '0;
      halted <= 1'b0;
      pc_wrapped <= 1'b0;
    end else if (redirect_valid && state != IDLE) begin
      pc <= redirect_pc[PC_W-1:0];
      if_valid <= 1'b0;
      halted <= 1'b0;
      state <= FETCH;
    end else if (adv) begin
      if_instr <= imem_data;
      if_pc <= {{(32-PC_W){1'b0}}, pc};
      if_valid <= 1'b1;
      if (is_halt) begin
        halted <= 1'b1;
        state <= HALTED;
      end else begin
        pc <= pc + 1'b1;
        if (&pc) pc_wrapped <= 1'b1;
      end
    end else begin
      if (if_valid && id_ready) if_valid <= 1'b0;
      if (state == IDLE && start) state <= FETCH;
    end
  end
endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb_instruction_fetch_unit: directed per-feature tests for the fetch stage
module tb_instruction_fetch_unit;
  logic clk = 0, rsta_n = 0, start = 0, redirect_valid = 0, id_ready = 1;
  logic [31:0] imem_addr, imem_data, redirect_pc = 0, if_instr, if_pc;
  logic if_valid, halted, pc_wrapped;
  logic [31:0] mem [128];
  int n_checks = 0, n_fail = 0;
  always #5 clk = ~clk;
  assign imem_data = mem[imem_addr[6:0]];
  instruction_fetch_unit dut (
    .clk(clk), .rsta_n(rsta_n), .start(start), .imem_addr(imem_addr),
    .imem_data(imem_data), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .id_ready(id_ready), .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
    .halted(halted), .pc_wrapped(pc_wrapped)
  );
  task step;
    @(posedge clk);
    #1;
  endtask
  task test_reset;
    rsta_n = 0;
    step();
    n_checks++; if (if_valid !== 1'b0) begin n_fail++; $display("FAIL reset if_valid: got %b expected 0", if_valid); end
    n_checks++; if (if_instr !== 32'h0) begin n_fail++; $display("FAIL reset if_instr: got %h expected 0", if_instr); end
    n_checks++; if (if_pc !== 32'h0) begin n_fail++; $display("FAIL reset if_pc: got %h expected 0", if_pc); end
    n_checks++; if (halted !== 1'b0) begin n_fail++; $display("FAIL reset halted: got %b expected 0", halted); end
    n_checks++; if (pc_wrapped !== 1'b0) begin n_fail++; $display("FAIL reset pc_wrapped: got %b expected 0", pc_wrapped); end
    n_checks++; if (imem_addr !== 32'h0) begin n_fail++; $display("FAIL reset imem_addr: got %h expected 0", imem_addr); end
    rsta_n = 1;
  endtask
  task test_sequential_fetch;
    start = 1;
    step();
    start = 0;
    n_checks++; if (if_valid !== 1'b0) begin n_fail++; $display("FAIL start_latency if_valid: got %b expected 0", if_valid); end
    for (int k = 0; k < 12; k++) begin
      step();
      n_checks++; if (if_valid !== 1'b1 || if_pc !== 32'(k)) begin n_fail++; $display("FAIL seq k=%0d: got valid=%b pc=%0d expected valid=1 pc=%0d", k, if_valid, if_pc, k); end
      n_checks++; if (if_instr !== mem[k]) begin n_fail++; $display("FAIL seq_instr k=%0d: got %h expected %h", k, if_instr, mem[k]); end
      n_checks++; if (halted !== (k == 11)) begin n_fail++; $display("FAIL seq_halted k=%0d: got %b expected %b", k, halted, k == 11); end
    end
    step();
    n_checks++; if (imem_addr !== 32'd11 || if_valid !== 1'b0 || halted !== 1'b1) begin n_fail++; $display("FAIL halt_hold: got addr=%0d valid=%b halted=%b expected 11 0 1", imem_addr, if_valid, halted); end
    step();
    n_checks++; if (imem_addr !== 32'd11) begin n_fail++; $display("FAIL halt_pc_stays: got %0d expected 11", imem_addr); end
  endtask
  task test_stall;
    redirect_valid = 1; redirect_pc = 0;
    step();
    redirect_valid = 0;
    for (int k = 0; k < 3; k++) step();
    n_checks++; if (if_pc !== 32'd2 || if_valid !== 1'b1) begin n_fail++; $display("FAIL stall_setup: got pc=%0d valid=%b expected 2 1", if_pc, if_valid); end
    id_ready = 0;
    for (int k = 0; k < 3; k++) begin
      step();
      n_checks++; if (if_pc !== 32'd2 || if_instr !== mem[2] || if_valid !== 1'b1 || imem_addr !== 32'd3) begin n_fail++; $display("FAIL stall_hold c=%0d: got pc=%0d instr=%h valid=%b addr=%0d expected 2 %h 1 3", k, if_pc, if_instr, if_valid, imem_addr, mem[2]); end
    end
    id_ready = 1;
    step();
    n_checks++; if (if_pc !== 32'd3 || if_valid !== 1'b1) begin n_fail++; $display("FAIL stall_release: got pc=%0d valid=%b expected 3 1", if_pc, if_valid); end
  endtask
  task test_redirect;
    for (int k = 0; k < 3; k++) step();
    n_checks++; if (if_pc !== 32'd6) begin n_fail++; $display("FAIL redirect_setup: got %0d expected 6", if_pc); end
    redirect_valid = 1; redirect_pc = 32'hFFFF_FF02;
    step();
    redirect_valid = 0;
    n_checks++; if (if_valid !== 1'b0 || imem_addr !== 32'd2) begin n_fail++; $display("FAIL redirect_flush: got valid=%b addr=%0d expected 0 2", if_valid, imem_addr); end
    step();
    n_checks++; if (if_valid !== 1'b1 || if_pc !== 32'd2 || if_instr !== mem[2]) begin n_fail++; $display("FAIL redirect_target: got valid=%b pc=%0d expected 1 2", if_valid, if_pc); end
  endtask
  task test_redirect_after_halt;
    for (int k = 0; k < 9; k++) step();
    n_checks++; if (if_pc !== 32'd11 || halted !== 1'b1) begin n_fail++; $display("FAIL halt2_setup: got pc=%0d halted=%b expected 11 1", if_pc, halted); end
    redirect_valid = 1; redirect_pc = 5; id_ready = 0;
    step();
    redirect_valid = 0;
    n_checks++; if (halted !== 1'b0 || if_valid !== 1'b0 || imem_addr !== 32'd5) begin n_fail++; $display("FAIL halt_redirect: got halted=%b valid=%b addr=%0d expected 0 0 5", halted, if_valid, imem_addr); end
    step();
    n_checks++; if (if_valid !== 1'b1 || if_pc !== 32'd5) begin n_fail++; $display("FAIL halt_resume: got valid=%b pc=%0d expected 1 5", if_valid, if_pc); end
    step();
    n_checks++; if (if_pc !== 32'd5 || imem_addr !== 32'd6) begin n_fail++; $display("FAIL halt_resume_stall: got pc=%0d addr=%0d expected 5 6", if_pc, imem_addr); end
    id_ready = 1;
  endtask
  task test_wrap;
    redirect_valid = 1; redirect_pc = 127;
    step();
    redirect_valid = 0;
    n_checks++; if (pc_wrapped !== 1'b0) begin n_fail++; $display("FAIL wrap_pre: got %b expected 0", pc_wrapped); end
    step();
    n_checks++; if (if_pc !== 32'd127 || imem_addr !== 32'd0) begin n_fail++; $display("FAIL wrap_127: got pc=%0d addr=%0d expected 127 0", if_pc, imem_addr); end
    step();
    n_checks++; if (if_pc !== 32'd0 || pc_wrapped !== 1'b1) begin n_fail++; $display("FAIL wrap_0: got pc=%0d wrapped=%b expected 0 1", if_pc, pc_wrapped); end
    step();
    n_checks++; if (if_pc !== 32'd1 || pc_wrapped !== 1'b1) begin n_fail++; $display("FAIL wrap_sticky: got pc=%0d wrapped=%b expected 1 1", if_pc, pc_wrapped); end
  endtask
  task test_midstream_reset;
    n_checks++; if (if_valid !== 1'b1) begin n_fail++; $display("FAIL mid_setup: got valid=%b expected 1", if_valid); end
    rsta_n = 0; start = 1; redirect_valid = 1; redirect_pc = 9;
    step();
    rsta_n = 1; start = 0; redirect_valid = 0;
    n_checks++; if (if_valid !== 1'b0 || if_pc !== 32'h0 || if_instr !== 32'h0 || halted !== 1'b0 || pc_wrapped !== 1'b0 || imem_addr !== 32'h0) begin n_fail++; $display("FAIL mid_reset: got valid=%b pc=%h instr=%h halted=%b wrapped=%b addr=%h expected all 0", if_valid, if_pc, if_instr, halted, pc_wrapped, imem_addr); end
    redirect_valid = 1; redirect_pc = 9;
    step();
    redirect_valid = 0;
    step();
    n_checks++; if (if_valid !== 1'b0 || imem_addr !== 32'h0) begin n_fail++; $display("FAIL idle_ignores: got valid=%b addr=%0d expected 0 0", if_valid, imem_addr); end
    start = 1;
    step();
    start = 0;
    step();
    n_checks++; if (if_valid !== 1'b1 || if_pc !== 32'd0 || if_instr !== mem[0]) begin n_fail++; $display("FAIL restart: got valid=%b pc=%0d expected 1 0", if_valid, if_pc); end
    step();
    n_checks++; if (if_pc !== 32'd1) begin n_fail++; $display("FAIL restart_next: got %0d expected 1", if_pc); end
  endtask
  initial begin
    for (int i = 0; i < 128; i++) mem[i] = {6'b000001, 10'h155, 16'(i)};
    mem[11] = {6'b111000, 26'h0ABCDE};
    test_reset();
    test_sequential_fetch();
    test_stall();
    test_redirect();
    test_redirect_after_halt();
    test_wrap();
    test_midstream_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
